// File: rtl/ysyx_24100006_pkg.sv
// rtl/ysyx_24100006_pkg.sv - shared IFU state encoding, reset PC and PC increment helper
package ysyx_24100006_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;

  // Plain 32-bit add: 0xFFFF_FFFC wraps to 0 with no carry out.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// rtl/ysyx_24100006_ifu.sv - single-outstanding instruction fetch unit; YSYX_24100006_IFU_PC_OUT_EN adds pc_o
module ysyx_24100006_ifu
  import ysyx_24100006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  input  logic [3:0]  irq_no_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_add_4_o,
  output logic        irq_o,
  output logic [3:0]  irq_no_o
`ifdef YSYX_24100006_IFU_PC_OUT_EN
  ,
  output logic [31:0] pc_o
`endif
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_drop;
  logic        w_drop_nxt;
  logic        w_capture;

  logic [31:0] r_instr;
  logic [31:0] r_pc_add_4;
  logic        r_irq;
  logic [3:0]  r_irq_no;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IFU_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop;
    w_capture   = 1'b0;
    case (r_state)
      IFU_IDLE: begin
        w_state_nxt = IFU_REQ;
        if (redirect_i) w_pc_nxt = redirect_pc_i;
      end
      IFU_REQ: begin
        if (redirect_i) w_pc_nxt = redirect_pc_i;
        // A redirect racing the accepted request poisons that fetch.
        if (mem_req_ready_i) begin
          w_state_nxt = IFU_WAIT;
          w_drop_nxt  = redirect_i;
        end
      end
      IFU_WAIT: begin
        if (redirect_i) w_pc_nxt = redirect_pc_i;
        if (mem_rsp_valid_i) begin
          w_drop_nxt = 1'b0;
          if (redirect_i || r_drop) begin
            w_state_nxt = IFU_REQ;
          end else begin
            w_state_nxt = IFU_OUT;
            w_capture   = 1'b1;
          end
        end else if (redirect_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      IFU_OUT: begin
        // Redirect wins over a simultaneous consumer handshake.
        if (redirect_i) begin
          w_state_nxt = IFU_REQ;
          w_pc_nxt    = redirect_pc_i;
        end else if (out_ready) begin
          w_state_nxt = IFU_REQ;
          w_pc_nxt    = pc_inc(r_pc);
        end
      end
      default: w_state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= '0;
      r_pc_add_4 <= '0;
      r_irq      <= 1'b0;
      r_irq_no   <= '0;
    end else if (w_capture) begin
      r_instr    <= mem_rsp_data_i;
      r_pc_add_4 <= pc_inc(r_pc);
      r_irq      <= irq_i;
      r_irq_no   <= irq_no_i;
    end
  end

`ifdef YSYX_24100006_IFU_PC_OUT_EN
  logic [31:0] r_pc_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_out <= '0;
    end else if (w_capture) begin
      r_pc_out <= r_pc;
    end
  end

  assign pc_o = r_pc_out;
`endif

  assign mem_req_valid_o = (r_state == IFU_REQ);
  assign mem_req_addr_o  = r_pc;
  assign out_valid       = (r_state == IFU_OUT);
  assign instruction_o   = r_instr;
  assign pc_add_4_o      = r_pc_add_4;
  assign irq_o           = r_irq;
  assign irq_no_o        = r_irq_no;

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// tb/tb_ysyx_24100006_ifu.sv - directed and randomized self-checking bench for the IFU
module tb_ysyx_24100006_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        irq_i = 1'b0;
  logic [3:0]  irq_no_i = '0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instruction_o;
  logic [31:0] pc_add_4_o;
  logic        irq_o;
  logic [3:0]  irq_no_o;
`ifdef YSYX_24100006_IFU_PC_OUT_EN
  logic [31:0] pc_o;
`endif

  int n_checks = 0;
  int n_fail = 0;

  ysyx_24100006_ifu dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .irq_i          (irq_i),
    .irq_no_i       (irq_no_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction_o  (instruction_o),
    .pc_add_4_o     (pc_add_4_o),
    .irq_o          (irq_o),
    .irq_no_o       (irq_no_o)
`ifdef YSYX_24100006_IFU_PC_OUT_EN
    ,
    .pc_o           (pc_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom % 4)
      0:       return 32'hFFFF_FFFC;
      1:       return 32'h8000_0000;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  // Reference model state: transaction-level view of fetches and deliveries.
  bit          m_pend, m_live, s_pend, first, real_rsp;
  int          m_cnt, delivered;
  logic [31:0] m_dut_addr, m_exp_addr, exp_addr, s_instr, s_pc4;
  logic        s_irq;
  logic [3:0]  s_irqno;

  initial begin
    tick();
    tick();
    check_eq("rst_req_valid", mem_req_valid_o, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_addr", mem_req_addr_o, 32'h3000_0000);
    check_eq("rst_instr", instruction_o, 32'h0);
    check_eq("rst_irq", irq_o, 1'b0);
    check_eq("rst_irq_no", irq_no_o, 4'd0);

    reset = 1'b0;
    check_eq("c1_req_valid", mem_req_valid_o, 1'b0);
    tick();
    check_eq("c2_req_valid", mem_req_valid_o, 1'b1);
    check_eq("c2_req_addr", mem_req_addr_o, 32'h3000_0000);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    check_eq("c3_req_valid", mem_req_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0013; irq_i = 1'b1; irq_no_i = 4'd7;
    check_eq("c4_out_valid", out_valid, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0; irq_i = 1'b0; irq_no_i = 4'd0;
    check_eq("c5_out_valid", out_valid, 1'b1);
    check_eq("c5_instr", instruction_o, 32'h0000_0013);
    check_eq("c5_pc4", pc_add_4_o, 32'h3000_0004);
    check_eq("c5_irq", irq_o, 1'b1);
    check_eq("c5_irq_no", irq_no_o, 4'd7);

    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_instr", instruction_o, 32'h0000_0013);
      check_eq("bp_pc4", pc_add_4_o, 32'h3000_0004);
      check_eq("bp_no_req", mem_req_valid_o, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_next_valid", mem_req_valid_o, 1'b1);
    check_eq("bp_next_addr", mem_req_addr_o, 32'h3000_0004);

    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000;
    tick();
    redirect_i = 1'b0;
    check_eq("wr_out_valid0", out_valid, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hDEAD_BEEF;
    check_eq("wr_out_valid1", out_valid, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
    check_eq("wr_drop_out", out_valid, 1'b0);
    check_eq("wr_req_valid", mem_req_valid_o, 1'b1);
    check_eq("wr_req_addr", mem_req_addr_o, 32'h8000_0000);

    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0010_0073;
    tick();
    mem_rsp_valid_i = 1'b0;
    check_eq("f2_out_valid", out_valid, 1'b1);
    check_eq("f2_instr", instruction_o, 32'h0010_0073);
    check_eq("f2_irq", irq_o, 1'b0);
    check_eq("f2_pc4", pc_add_4_o, 32'h8000_0004);

    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; out_ready = 1'b1;
    tick();
    redirect_i = 1'b0; out_ready = 1'b0;
    check_eq("ro_out_valid", out_valid, 1'b0);
    check_eq("ro_req_valid", mem_req_valid_o, 1'b1);
    check_eq("ro_req_addr", mem_req_addr_o, 32'hFFFF_FFFC);

    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0013;
    tick();
    mem_rsp_valid_i = 1'b0;
    check_eq("wrap_pc4", pc_add_4_o, 32'h0000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("wrap_req_addr", mem_req_addr_o, 32'h0000_0000);

    redirect_i = 1'b1; redirect_pc_i = 32'h1234_5670;
    tick();
    redirect_i = 1'b0;
    check_eq("rq_req_valid", mem_req_valid_o, 1'b1);
    check_eq("rq_req_addr", mem_req_addr_o, 32'h1234_5670);

    mem_req_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h2000_0000;
    tick();
    mem_req_ready_i = 1'b0; redirect_i = 1'b0;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0001;
    tick();
    mem_rsp_valid_i = 1'b0;
    check_eq("rqhs_out_valid", out_valid, 1'b0);
    check_eq("rqhs_req_addr", mem_req_addr_o, 32'h2000_0000);

    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req", mem_req_valid_o, 1'b0);
    check_eq("mid_rst_out", out_valid, 1'b0);
    check_eq("mid_rst_addr", mem_req_addr_o, 32'h3000_0000);
    tick();
    tick();

    reset = 1'b0;
    m_pend = 0; m_live = 0; s_pend = 0; first = 1; delivered = 0; m_cnt = 0;
    exp_addr = 32'h3000_0000;
    s_instr = '0; s_pc4 = '0; s_irq = 1'b0; s_irqno = '0; m_dut_addr = '0; m_exp_addr = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      mem_req_ready_i = ($urandom % 3) != 0;
      out_ready       = ($urandom % 4) != 0;
      redirect_i      = !first && (($urandom % 12) == 0);
      redirect_pc_i   = pick_target();
      irq_i           = $urandom % 2;
      irq_no_i        = 4'($urandom);
      real_rsp        = m_pend && (m_cnt == 0);
      mem_rsp_valid_i = real_rsp || (!m_pend && (($urandom % 8) == 0));
      mem_rsp_data_i  = real_rsp ? memfn(m_dut_addr) : $urandom;

      check_eq("rnd_req_valid", mem_req_valid_o, !m_pend && !s_pend && !first);
      if (mem_req_valid_o) check_eq("rnd_req_addr", mem_req_addr_o, exp_addr);
      check_eq("rnd_out_valid", out_valid, s_pend);
      if (s_pend) begin
        check_eq("rnd_instr", instruction_o, s_instr);
        check_eq("rnd_pc4", pc_add_4_o, s_pc4);
        check_eq("rnd_irq", irq_o, s_irq);
        check_eq("rnd_irq_no", irq_no_o, s_irqno);
`ifdef YSYX_24100006_IFU_PC_OUT_EN
        check_eq("rnd_pc_o", pc_o, s_pc4 - 32'd4);
`endif
      end

      if (s_pend && redirect_i) begin
        s_pend = 0;
      end else if (s_pend && out_ready) begin
        s_pend = 0;
        exp_addr = s_pc4;
        delivered++;
      end
      if (mem_req_valid_o && mem_req_ready_i && !m_pend) begin
        m_pend = 1;
        m_live = !redirect_i;
        m_cnt = $urandom_range(0, 3);
        m_dut_addr = mem_req_addr_o;
        m_exp_addr = exp_addr;
      end else if (m_pend) begin
        if (real_rsp) begin
          m_pend = 0;
          if (m_live && !redirect_i) begin
            s_pend = 1;
            s_instr = memfn(m_exp_addr);
            s_pc4 = m_exp_addr + 32'd4;
            s_irq = irq_i;
            s_irqno = irq_no_i;
          end
        end else begin
          m_cnt--;
        end
      end
      if (redirect_i) begin
        m_live = 0;
        exp_addr = redirect_pc_i;
      end
      first = 0;
      tick();
    end
    check_eq("rnd_liveness", delivered > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_ifu.md
YSYX_24100006_IFU -- requirements
Module: ysyx_24100006_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h3000_0000: first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port redirect_i  input  1  flush request; PC is reloaded from redirect_pc_i.
REQ-005 SHALL have port redirect_pc_i  input  32  redirect target, with bits [1:0] = 0.
REQ-006 SHALL have ports irq_i  input  1 and irq_no_i  input  4  interrupt level and cause number.
REQ-007 SHALL have ports mem_req_valid_o  output  1, mem_req_ready_i  input  1, mem_req_addr_o  output  32  fetch request channel.
REQ-008 SHALL have ports mem_rsp_valid_i  input  1 and mem_rsp_data_i  input  32  fetch response channel, with no backpressure.
REQ-009 SHALL have ports out_valid  output  1 and out_ready  input  1  handshake to the IF/ID register.
REQ-010 SHALL have ports instruction_o  output  32, pc_add_4_o  output  32, irq_o  output  1, irq_no_o  output  4  payload to IF/ID.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT, OUT, which are mutually exclusive.
REQ-012 SHALL make these transitions: IDLE->REQ unconditionally; REQ->WAIT on mem_req_valid_o&&mem_req_ready_i; WAIT->OUT on mem_rsp_valid_i with no pending drop; OUT->REQ on out_valid&&out_ready.
REQ-013 SHALL drive mem_req_valid_o=1 only in REQ, with mem_req_addr_o=pc_q.
REQ-014 SHALL drive out_valid=1 only in OUT; the payload SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-015 SHALL capture mem_rsp_data_i into instruction_o on the accepting WAIT->OUT edge, so latency is response cycle +1.
REQ-016 SHALL set pc_add_4_o = pc_q+4, computed in 32 bits with wrap 0xFFFF_FFFC->0x0000_0000 and no overflow flag.
REQ-017 SHALL update pc_q to pc_q+4 on the OUT handshake.
REQ-018 SHALL sample irq_i/irq_no_i in the cycle the response is accepted and present them as irq_o/irq_no_o with that instruction.
REQ-019 SHALL, when redirect_i=1 in REQ without a handshake, load pc_q<=redirect_pc_i and stay in REQ; mem_req_addr_o SHALL change the next cycle.
REQ-020 SHALL, when redirect_i=1 in REQ with a handshake in the same cycle, go to WAIT, set drop_q, and load pc_q.
REQ-021 SHALL, when redirect_i=1 in WAIT, set drop_q and load pc_q; if mem_rsp_valid_i is high in the same cycle, it SHALL discard that response, go to REQ, and leave drop_q clear.
REQ-022 SHALL, on a response in WAIT with drop_q=1, discard the data, clear drop_q, and go to REQ without asserting out_valid.
REQ-023 SHALL, when redirect_i=1 in OUT, deassert out_valid the next cycle, go to REQ with pc_q=redirect_pc_i, and give redirect priority over a simultaneous out handshake.
REQ-024 SHALL keep at most one fetch outstanding, and SHALL ignore mem_rsp_valid_i outside WAIT.

Reset
REQ-025 SHALL, on reset, go to state=IDLE, pc_q=RESET_PC, drop_q=0, out_valid=0, mem_req_valid_o=0, irq_o=0, irq_no_o=0, instruction_o=0; this reset SHALL be asynchronous.
REQ-026 SHALL assert mem_req_valid_o with addr RESET_PC in the 2nd cycle after reset deasserts.
REQ-027 SHALL, when reset is asserted mid-fetch, abandon the fetch; the memory side is reset by the same signal.

Configuration
REQ-028 SHALL, with YSYX_24100006_IFU_PC_OUT_EN defined, add output pc_o (32 bits) = the address of instruction_o, registered with the payload.
REQ-029 SHALL, without YSYX_24100006_IFU_PC_OUT_EN, have no pc_o port and no pc_o register; all other behaviour is identical.

Structure
REQ-030 SHALL take the FSM state encoding (2 bits) and the RESET_PC default from the shared package ysyx_24100006_pkg.
REQ-031 SHALL be a single module with no sub-modules; the FSM, pc_q, drop_q and the payload registers are inline.

Verification
REQ-032 SHALL cover reset release: mem_req_addr_o=0x3000_0000 at cycle 2; ready=1 and rsp at cycle 4 with data 0x00000013 -> out_valid at cycle 5, instruction_o=0x13, pc_add_4_o=0x3000_0004.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles -> payload constant and no new mem request; out_ready=1 -> next request addr 0x3000_0004.
REQ-034 SHALL cover redirect in WAIT to 0x8000_0000, with the stale rsp arriving 2 cycles later -> rsp dropped, out_valid stays 0, next request addr 0x8000_0000.
REQ-035 SHALL cover redirect and out handshake in the same cycle in OUT -> next request addr = redirect_pc_i, not pc+4.
REQ-036 SHALL cover irq_i=1, irq_no_i=4'd7 during the response cycle -> irq_o=1, irq_no_o=7 with that instruction; irq_i=0 on the next fetch -> irq_o=0.
REQ-037 SHALL cover pc wrap: redirect to 0xFFFF_FFFC -> pc_add_4_o=0x0000_0000, and the next request addr is 0x0000_0000.
